// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// the reset instruction (nop), the halting syscall number and a small
// alignment helper used when FETCH_MISALIGN_CHECK_EN is defined.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

  // addi x0, x0, 0 -- what decode sees before the first fetch completes
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // a7 (x17) value that turns an ecall into a CPU halt; decode evaluates it
  localparam int unsigned HALT_SYSCALL = 10;

  // A fetch target is word-aligned only when its two low bits are zero
  function automatic logic addr_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// next_pc_sel: combinational priority mux selecting the PC that follows the
// presented instruction (jalr > jal > taken branch > pc+4). The ecall halt
// is handled by the FSM in fetch_unit, not here.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN -- when defined, flags a
// selected target whose two low bits are non-zero; otherwise the flag is 0.
module next_pc_sel
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic            branch,
  input  logic            bcond,
  output logic [XLEN-1:0] next_pc,
  output logic            target_misaligned
);

  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] rel_target;
  logic [XLEN-1:0] seq_target;

  assign jalr_sum   = rs1_data + imm;
  assign rel_target = pc + imm;
  assign seq_target = pc + XLEN'(4);

  // Priority select of the next PC; arithmetic wraps silently
  always_comb begin
    next_pc = seq_target;
    if (is_jalr) begin
      next_pc = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (is_jal) begin
      next_pc = rel_target;
    end else if (branch && bcond) begin
      next_pc = rel_target;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  assign target_misaligned = addr_misaligned(next_pc[1:0]);
`else
  assign target_misaligned = 1'b0;
`endif

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: holds the architectural PC, fetches one instruction at a time
// from a variable-latency memory and presents it to decode.
// Handshake: imem_req stays high in FETCH until imem_ready; inst_valid stays
// high in ISSUE, with inst/pc stable, until decode answers with inst_ready.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned target halts
// the CPU with misaligned=1 instead of loading; see next_pc_sel).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            inst_valid,
  input  logic            inst_ready,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic            branch,
  input  logic            is_ecall,
  input  logic            bcond,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            ecall_halt,
  output logic            is_halted,
  output logic            misaligned
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic            misaligned_q, misaligned_d;

  logic [XLEN-1:0] next_pc;
  logic            target_misaligned;

  // A non-halting ecall simply falls through to pc+4, so the raw flag is
  // not needed; decode already folds it into ecall_halt.
  logic unused_is_ecall;
  assign unused_is_ecall = is_ecall;

  next_pc_sel #(
    .XLEN(XLEN)
  ) u_next_pc_sel (
    .pc               (pc_q),
    .imm              (imm),
    .rs1_data         (rs1_data),
    .is_jal           (is_jal),
    .is_jalr          (is_jalr),
    .branch           (branch),
    .bcond            (bcond),
    .next_pc          (next_pc),
    .target_misaligned(target_misaligned)
  );

  // State and datapath registers; reset overrides everything, HALT included
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      inst_q       <= NOP_INST;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Next-state and register-update logic
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    misaligned_d = misaligned_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ready) begin
          inst_d  = imem_rdata;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (inst_ready) begin
          if (ecall_halt) begin
            state_d = ST_HALT;
          end else if (target_misaligned) begin
            // pc keeps the offending instruction's address
            state_d      = ST_HALT;
            misaligned_d = 1'b1;
          end else begin
            pc_d    = next_pc;
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    is_halted  = 1'b0;
    case (state_q)
      ST_FETCH: imem_req   = 1'b1;
      ST_ISSUE: inst_valid = 1'b1;
      ST_HALT:  is_halted  = 1'b1;
      default:  imem_req   = 1'b0;
    endcase
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign pc_plus4   = pc_q + XLEN'(4);
  assign inst       = inst_q;
  assign misaligned = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed redirect/halt/reset scenarios followed
// by randomized instruction streams with random memory waits and decode
// stalls. A reference model tracks the architectural PC from the ISA rules;
// a monitor checks every cycle against the scoreboard queue.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          XLEN        = 32;
  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  localparam int PH_IDLE  = 0;
  localparam int PH_FETCH = 1;
  localparam int PH_ISSUE = 2;
  localparam int PH_HALT  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_rdata;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            inst_valid;
  logic            inst_ready;
  logic            is_jal, is_jalr, branch, is_ecall, bcond;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_data;
  logic            ecall_halt;
  logic            is_halted;
  logic            misaligned;

  fetch_unit #(
    .XLEN    (XLEN),
    .RESET_PC(TB_RESET_PC)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .inst      (inst),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .is_jal    (is_jal),
    .is_jalr   (is_jalr),
    .branch    (branch),
    .is_ecall  (is_ecall),
    .bcond     (bcond),
    .imm       (imm),
    .rs1_data  (rs1_data),
    .ecall_halt(ecall_halt),
    .is_halted (is_halted),
    .misaligned(misaligned)
  );

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_q[$];        // {pc, inst} of the instruction in flight
  int          total = 0;
  int          bad   = 0;
  int          phase = PH_IDLE; // what the driver expects the DUT to do now
  logic [31:0] model_pc;
  bit          model_halted;
  logic [31:0] halt_pc;
  bit          exp_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level next-PC rule, written directly from the ISA semantics
  function automatic logic [31:0] model_target(input logic [31:0] cur_pc,
                                               input bit jal, input bit jalr,
                                               input bit br, input bit bc,
                                               input logic [31:0] imm_v,
                                               input logic [31:0] rs1_v);
    if (jalr) return (rs1_v + imm_v) & 32'hFFFF_FFFE;
    if (jal) return cur_pc + imm_v;
    if (br && bc) return cur_pc + imm_v;
    return cur_pc + 32'd4;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    case (phase)
      PH_FETCH: begin
        if (exp_q.size() == 0) begin
          chk("fetch_queue_nonempty", 32'd0, 32'd1);
        end else begin
          chk("fetch_req", {31'd0, imem_req}, 32'd1);
          chk("fetch_valid_low", {31'd0, inst_valid}, 32'd0);
          chk("fetch_addr", imem_addr, exp_q[0][63:32]);
        end
      end
      PH_ISSUE: begin
        if (exp_q.size() == 0) begin
          chk("issue_queue_nonempty", 32'd0, 32'd1);
        end else begin
          chk("issue_valid", {31'd0, inst_valid}, 32'd1);
          chk("issue_req_low", {31'd0, imem_req}, 32'd0);
          chk("issue_pc", pc, exp_q[0][63:32]);
          chk("issue_inst", inst, exp_q[0][31:0]);
          chk("issue_pc_plus4", pc_plus4, exp_q[0][63:32] + 32'd4);
          if (inst_ready) void'(exp_q.pop_front());
        end
      end
      PH_HALT: begin
        chk("halt_flag", {31'd0, is_halted}, 32'd1);
        chk("halt_req_low", {31'd0, imem_req}, 32'd0);
        chk("halt_valid_low", {31'd0, inst_valid}, 32'd0);
        chk("halt_pc", pc, halt_pc);
        chk("halt_misaligned", {31'd0, misaligned}, {31'd0, exp_mis});
      end
      default: ;
    endcase
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive controls with junk; the DUT must ignore them outside ISSUE
  task automatic junk_ctrl();
    inst_ready = 1'($urandom);
    is_jal     = 1'($urandom);
    is_jalr    = 1'($urandom);
    branch     = 1'($urandom);
    bcond      = 1'($urandom);
    is_ecall   = 1'($urandom);
    ecall_halt = 1'($urandom);
    imm        = $urandom;
    rs1_data   = $urandom;
  endtask

  task automatic do_reset();
    phase      = PH_IDLE;
    reset_n    = 1'b0;
    imem_ready = 1'b0;
    junk_ctrl();
    step();
    chk("rst_pc", pc, TB_RESET_PC);
    chk("rst_inst", inst, NOP_INST);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_halted", {31'd0, is_halted}, 32'd0);
    chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("rst_first_req", {31'd0, imem_req}, 32'd1);
    exp_q.delete();
    model_pc     = TB_RESET_PC;
    model_halted = 1'b0;
    exp_mis      = 1'b0;
  endtask

  // One instruction: memory wait, fetch, decode stall, retire
  task automatic do_instr(input bit jal, input bit jalr, input bit br, input bit bc,
                          input bit ec, input bit eh,
                          input logic [31:0] imm_v, input logic [31:0] rs1_v,
                          input int wait_n, input int stall_n);
    logic [31:0] word;
    logic [31:0] tgt;
    word = $urandom;
    exp_q.push_back({model_pc, word});
    phase = PH_FETCH;
    imem_ready = 1'b0;
    for (int i = 0; i < wait_n; i++) begin
      junk_ctrl();
      imem_rdata = $urandom;
      step();
    end
    junk_ctrl();
    imem_ready = 1'b1;
    imem_rdata = word;
    step();
    phase      = PH_ISSUE;
    is_jal     = jal;
    is_jalr    = jalr;
    branch     = br;
    bcond      = bc;
    is_ecall   = ec;
    ecall_halt = eh;
    imm        = imm_v;
    rs1_data   = rs1_v;
    inst_ready = 1'b0;
    for (int i = 0; i < stall_n; i++) begin
      imem_ready = 1'($urandom);
      imem_rdata = $urandom;
      step();
    end
    inst_ready = 1'b1;
    step();
    tgt = model_target(model_pc, jal, jalr, br, bc, imm_v, rs1_v);
    if (eh) begin
      model_halted = 1'b1;
      halt_pc      = model_pc;
      exp_mis      = 1'b0;
    end else if (MIS_EN && (tgt[1:0] != 2'b00)) begin
      model_halted = 1'b1;
      halt_pc      = model_pc;
      exp_mis      = 1'b1;
    end else begin
      model_pc = tgt;
    end
    phase      = model_halted ? PH_HALT : PH_IDLE;
    imem_ready = 1'b0;
    junk_ctrl();
  endtask

  task automatic plain(input int wait_n, input int stall_n);
    do_instr(0, 0, 0, 0, 0, 0, 32'd0, 32'd0, wait_n, stall_n);
  endtask

  task automatic hold_halt(input int n);
    for (int i = 0; i < n; i++) begin
      junk_ctrl();
      imem_ready = 1'($urandom);
      imem_rdata = $urandom;
      step();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r_imm;
    logic [31:0] r_rs1;
    int          kind;
    reset_n    = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
    junk_ctrl();
    step();
    do_reset();

    // sequential fetch 0,4, then wait/stall at pc=8
    plain(0, 0);
    plain(0, 0);
    plain(3, 2);
    plain(0, 0);
    // redirects
    do_instr(1, 0, 0, 0, 0, 0, 32'hFFFF_FFF8, 32'd0, 0, 0);      // jal 16-8 -> 8
    do_instr(0, 1, 0, 0, 0, 0, 32'd4, 32'h0000_0101, 1, 0);      // jalr -> 0x104
    do_instr(0, 0, 1, 0, 0, 0, 32'd12, 32'd0, 0, 1);             // not taken -> 0x108
    do_instr(0, 0, 1, 1, 0, 0, 32'd12, 32'd0, 0, 0);             // taken -> 0x114
    do_instr(1, 1, 1, 1, 0, 0, 32'd0, 32'h0000_0200, 0, 0);      // jalr wins -> 0x200
    do_instr(0, 0, 0, 0, 1, 0, 32'h0000_0040, 32'd0, 0, 0);      // non-halt ecall -> 0x204

    // randomized aligned stream
    for (int n = 0; n < 40; n++) begin
      kind  = $urandom_range(0, 4);
      r_imm = ($urandom & 32'h0000_0FFC) - 32'h0000_0800;
      r_rs1 = ($urandom & 32'h0000_FFFC) | 32'($urandom_range(0, 1));
      case (kind)
        0: do_instr(1, 0, 0, 0, 0, 0, r_imm, r_rs1, $urandom_range(0, 3), $urandom_range(0, 3));
        1: do_instr(0, 1, 0, 0, 0, 0, r_imm, r_rs1, $urandom_range(0, 3), $urandom_range(0, 3));
        2: do_instr(0, 0, 1, 1'($urandom), 0, 0, r_imm, r_rs1, $urandom_range(0, 3), $urandom_range(0, 3));
        default: do_instr(0, 0, 0, 0, 0, 0, r_imm, r_rs1, $urandom_range(0, 3), $urandom_range(0, 3));
      endcase
    end

    // wrap-around: jump to 0xFFFF_FFFC, then fall through to 0
    do_instr(0, 1, 0, 0, 0, 0, 32'h0000_000C, 32'hFFFF_FFF0, 0, 0);
    plain(1, 1);
    chk("wrap_model_pc", model_pc, 32'd0);

    // halt at 0x20
    do_instr(1, 0, 0, 0, 0, 0, 32'h0000_0020, 32'd0, 0, 0);
    do_instr(0, 0, 0, 0, 1, 1, 32'd0, 32'd0, 2, 1);
    hold_halt(10);
    do_reset();

    // reset while a fetch is outstanding, then late ready accepted
    imem_ready = 1'b0;
    step();
    step();
    do_reset();
    plain(0, 0);

    // misaligned jal target 4+6
    do_instr(1, 0, 0, 0, 0, 0, 32'd6, 32'd0, 0, 0);
    if (model_halted) begin
      hold_halt(3);
    end else begin
      plain(0, 0);
      plain(1, 0);
    end
    do_reset();
    plain(0, 0);

    phase = PH_IDLE;
    step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
